// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: reads fetch addresses from program memory
// and returns tagged instruction words through a small response FIFO.
module instr_fetch_responder #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [ADDR_W-1:0]             req_addr,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_instr,
    output logic [ADDR_W-1:0]             rsp_addr,
    input  logic                          prog_we,
    input  logic [ADDR_W-1:0]             prog_addr,
    input  logic [DATA_W-1:0]             prog_data,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [DATA_W-1:0] s1_instr;

    logic [DATA_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_addr  [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    logic [DATA_W-1:0] last_instr;
    logic [ADDR_W-1:0] last_addr;

    logic [CW:0]       used;
    logic              accept;
    logic              push;
    logic              pop;

    // Slots are reserved at accept time: S1 always has a FIFO entry waiting.
    assign used      = {1'b0, occupancy} + {{CW{1'b0}}, s1_valid};
    assign req_ready = !flush && (used < (CW+1)'(FIFO_DEPTH));
    assign accept    = req_valid && req_ready;
    assign push      = s1_valid && !flush;
    assign rsp_valid = (occupancy != '0);
    assign pop       = rsp_valid && rsp_ready;

    assign rsp_instr = rsp_valid ? fifo_instr[rd_ptr] : last_instr;
    assign rsp_addr  = rsp_valid ? fifo_addr[rd_ptr]  : last_addr;

    // Program memory write port and S1 capture; the read sees pre-write data.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem[prog_addr] <= prog_data;
        end
        if (accept) begin
            s1_addr  <= req_addr;
            s1_instr <= mem[req_addr];
        end
    end

    // Response storage; written only when S1 drains into the FIFO.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= s1_instr;
            fifo_addr[wr_ptr]  <= s1_addr;
        end
    end

    // Pipeline valid, FIFO pointers and occupancy; flush empties everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else if (flush) begin
            s1_valid  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
        end else begin
            s1_valid <= accept;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // Remember the last consumed response so idle outputs stay steady.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_instr <= '0;
            last_addr  <= '0;
        end else if (pop) begin
            last_instr <= fifo_instr[rd_ptr];
            last_addr  <= fifo_addr[rd_ptr];
        end
    end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
Responder side of the program-counter address stream. It accepts 8-bit fetch addresses over a valid/ready request channel and reads each one from an internal instruction memory. It returns the instruction word, tagged with its address, over a valid/ready response channel, with an output FIFO to absorb back-pressure. It also provides a program-load write port and a flush input for redirects.

Parameters:
DATA_W, 16, instruction word width in bits
ADDR_W, 8, address width; memory holds 2**ADDR_W words
FIFO_DEPTH, 4, response FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous; discards in-flight and buffered responses
req_valid  input  1  fetch request valid
req_ready  output  1  responder can accept a request this cycle
req_addr  input  ADDR_W  fetch address
rsp_valid  output  1  FIFO head holds a valid response
rsp_ready  input  1  consumer accepts the head this cycle
rsp_instr  output  DATA_W  instruction word at the FIFO head
rsp_addr  output  ADDR_W  address that produced rsp_instr
prog_we  input  1  memory write enable
prog_addr  input  ADDR_W  memory write address
prog_data  input  DATA_W  memory write data
occupancy  output  $clog2(FIFO_DEPTH)+1  FIFO entries currently held

Behaviour:
- Reset (clk is the clock; rst is asynchronous and active-high):
  - s1_valid, FIFO pointers and occupancy go to 0.
  - rsp_valid = 0, rsp_instr = 0, rsp_addr = 0.
  - req_ready goes high on the first cycle after rst deasserts.
  - Memory contents are not reset and persist across rst.
- Accept rule: a request is accepted when req_valid && req_ready at a rising edge.
- req_ready = !flush && (occupancy + s1_valid < FIFO_DEPTH).
  - This is combinational from registered state plus flush only; it never depends on req_valid.
- Pipeline:
  - Stage S1 registers {addr, mem[addr]} when a request is accepted; s1_valid = 1 in the following cycle.
  - In any cycle with s1_valid = 1, the S1 contents are pushed into the FIFO at the next edge. This push is unconditional, because space was reserved at accept time.
- Latency: a request accepted at edge N makes its response visible at the FIFO head (rsp_valid = 1) after edge N+1, i.e. 2 cycles.
- Throughput: with rsp_ready held high, one response per cycle with no bubbles.
- Ordering: responses leave in strict request order.
- Output: rsp_instr and rsp_addr come combinationally from the FIFO head.
  - When empty, they hold the last popped value, or 0 after reset.
- Pop: on rsp_valid && rsp_ready. A push and a pop in the same cycle leave occupancy unchanged.
- Back-pressure: rsp_valid and the head data stay stable while rsp_ready = 0.
- Full: occupancy + s1_valid = FIFO_DEPTH forces req_ready = 0.
  - A pop in that cycle does not raise req_ready until the next cycle.
- Pointer arithmetic: wr_ptr and rd_ptr are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.
- Flush:
  - In the flush cycle, req_ready = 0, so no request is accepted.
  - At the next edge, s1_valid and occupancy go to 0 and the pointers go to 0.
  - A pop in the flush cycle is still legal; the popped data is considered consumed.
  - A flush held over multiple cycles keeps the block empty.
- Program write:
  - mem[prog_addr] <= prog_data on prog_we.
  - A read of the same address in the same cycle returns the OLD data (read-before-write).
  - Writes are allowed at any time, including mid-stream.
- rst asserted mid-stream: all in-flight and buffered responses are lost immediately and the outputs return to their reset values.

Test Plan:
- Load mem[0..3] = 16'h1111, 2222, 3333, 4444; then request addr 0..3 back-to-back with rsp_ready = 1 -> rsp_valid first appears 2 cycles after the first accept; responses are 1111, 2222, 3333, 4444 on consecutive cycles with rsp_addr 0..3; req_ready stays 1 throughout.
- Hold rsp_ready = 0 and stream requests addr 0,1,2,... -> exactly 4 accepts (occupancy + s1_valid reaches 4), then req_ready = 0 and occupancy = 4 with head 1111 held stable. Then set rsp_ready = 1 -> drains in order, and req_ready = 1 again the cycle after the first pop.
- Request addr 8'hFF, then addr 8'h00 -> responses in order, with rsp_addr FF then 00; after more than 4 push/pop pairs, the wrapped pointers still give correct order.
- Fill 3 entries, then pulse flush for 1 cycle together with req_valid = 1 -> that request is not accepted (req_ready = 0); next cycle occupancy = 0 and rsp_valid = 0; a new request to addr 2 returns 3333.
- In the same cycle, prog_we writes mem[5] = 16'hBEEF and a request to addr 5 is accepted -> response is the old mem[5]; a later request to addr 5 returns BEEF.
- Assert rst asynchronously mid-stream with occupancy 2 -> rsp_valid, occupancy, rsp_instr and rsp_addr drop to 0 without waiting for an edge; after release, mem contents are intact and a new request to addr 0 returns 1111.
